// File: rtl/bcd_tick_pkg.sv
// Shared state encoding and BCD digit constants for the stopwatch counter.
package bcd_tick_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the stopwatch: counts 0..9 and ripples a carry on 9->0.
module bcd_digit
  import bcd_tick_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  assign carry = inc & (q == BCD_MAX);

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      q <= '0;
    end else if (inc) begin
      q <= (q == BCD_MAX) ? '0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_tick_counter.sv
// Multi-digit BCD stopwatch: run/pause/clear FSM over a chain of bcd_digit cells.
// Optional lap freeze of the displayed count is enabled by BCD_TICK_LAP_HOLD_EN.
module bcd_tick_counter
  import bcd_tick_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int WRAP   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic                      start_stop,
  input  logic                      clear,
`ifdef BCD_TICK_LAP_HOLD_EN
  input  logic                      lap,
  output logic                      lap_hold,
`endif
  output logic [BCD_W*DIGITS-1:0]   count,
  output logic                      running,
  output logic                      carry_out,
  output logic                      done
);

  state_t                    state;
  logic [BCD_W*DIGITS-1:0]   live;
  logic [DIGITS:0]           chain;
  logic [DIGITS-1:0]         nine;
  logic                      all_nines;
  logic                      hold_max;

  assign all_nines = &nine;
  // Without wrap the terminal tick must not roll the digits, so the increment is suppressed.
  assign hold_max  = (WRAP == 0) && all_nines;
  assign chain[0]  = (state == RUN) && tick && !hold_max;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .rst   (rst),
      .inc   (chain[i]),
      .clr   (clear),
      .q     (live[i*BCD_W +: BCD_W]),
      .carry (chain[i+1])
    );
    assign nine[i] = (live[i*BCD_W +: BCD_W] == BCD_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      state     <= IDLE;
      running   <= 1'b0;
      carry_out <= 1'b0;
      done      <= 1'b0;
    end else begin
      carry_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_stop) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (tick && hold_max) begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end else begin
            carry_out <= chain[DIGITS];
            if (start_stop) begin
              state   <= PAUSE;
              running <= 1'b0;
            end
          end
        end
        PAUSE: begin
          if (start_stop) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BCD_TICK_LAP_HOLD_EN
  logic [BCD_W*DIGITS-1:0] frozen;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      lap_hold <= 1'b0;
      frozen   <= '0;
    end else if (lap && state == RUN) begin
      lap_hold <= !lap_hold;
      frozen   <= live;
    end
  end

  assign count = lap_hold ? frozen : live;
`else
  assign count = live;
`endif

endmodule
